// File: rtl/rvfi_harness_pkg.sv
// rvfi_harness_pkg: shared types and helpers for the RVFI memory harness.
// The request record is sized to the widest supported configuration; each
// module slices out the lanes it was parameterised for.
package rvfi_harness_pkg;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_MASK_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_MASK_W-1:0] rmask;
    logic [MAX_MASK_W-1:0] wmask;
    logic [MAX_DATA_W-1:0] wdata;
  } mem_req_t;

  // Expand a byte-lane mask into a bit mask (one byte of ones per set lane).
  function automatic logic [MAX_DATA_W-1:0] lane_mask(input logic [MAX_MASK_W-1:0] byte_mask);
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_MASK_W; i++) begin
      bits[i*8 +: 8] = {8{byte_mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/rvfi_mem_store.sv
// rvfi_mem_store: DEPTH-word byte-writable flop array backing the harness.
// Only instantiated when RVFI_MEM_BACKING_EN is defined. Read is
// combinational from the addressed word; writes merge the enabled lanes.
module rvfi_mem_store
  import rvfi_harness_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int MASK_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [MASK_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [MAX_DATA_W-1:0] wbits_full;
  logic [DATA_W-1:0]     wbits;
  logic                  unused_bits;

  assign wbits_full  = lane_mask(MAX_MASK_W'(wmask));
  assign wbits       = wbits_full[DATA_W-1:0];
  assign unused_bits = ^wbits_full;
  assign rdata       = mem[idx];

  // Clear every word on reset, otherwise merge the enabled write lanes
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= (mem[idx] & ~wbits) | (wdata & wbits);
    end
  end

endmodule

// File: rtl/rvfi_mem_harness.sv
// rvfi_mem_harness: valid/ready memory model for the RVFI harness.
// Each accepted request waits min(rnd_wait, MAX_WAIT) cycles, then issues a
// one-cycle response. Define RVFI_MEM_BACKING_EN to back it with a word store;
// without it writes are dropped and reads return rnd_data under the read mask.
module rvfi_mem_harness
  import rvfi_harness_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3,
  parameter int DEPTH    = 16,
  localparam int MASK_W  = DATA_W / 8,
  localparam int WAIT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_rmask,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [WAIT_W-1:0] rnd_wait,
  input  logic [DATA_W-1:0] rnd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t                state;
  state_t                next_state;
  logic [WAIT_W-1:0]     cnt;
  logic [WAIT_W-1:0]     next_cnt;
  logic                  accept;
  mem_req_t              req;
  logic                  is_err;
  logic [MAX_DATA_W-1:0] rmask_bits;
  logic [DATA_W-1:0]     read_word;
  logic                  unused_bits;

  assign is_err     = (|req.rmask) && (|req.wmask);
  assign rmask_bits = lane_mask(req.rmask);

`ifdef RVFI_MEM_BACKING_EN
  localparam int IDX_W = $clog2(DEPTH);

  logic              store_we;
  logic [DATA_W-1:0] store_rdata;

  // A conflicting request never touches the store; the write lands on the RESP edge.
  assign store_we  = (state == RESP) && !is_err && (|req.wmask);
  assign read_word = store_rdata;

  rvfi_mem_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clock (clock),
    .reset (reset),
    .we    (store_we),
    .idx   (req.addr[IDX_W+1:2]),
    .wmask (req.wmask[MASK_W-1:0]),
    .wdata (req.wdata[DATA_W-1:0]),
    .rdata (store_rdata)
  );
`else
  assign read_word = rnd_data;
`endif

  assign unused_bits = ^{req, rmask_bits, rnd_data, DEPTH == 0};

  // Next-state, wait counter and accept decode
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (int'(rnd_wait) > MAX_WAIT) begin
            next_cnt = WAIT_W'(MAX_WAIT);
          end else begin
            next_cnt = rnd_wait;
          end
          if (next_cnt == WAIT_W'(0)) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        next_cnt = cnt - WAIT_W'(1);
        if (cnt == WAIT_W'(1)) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = WAIT_W'(0);
      end
    endcase
  end

  // State, counter and captured request; reset wins over a same-cycle request
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= WAIT_W'(0);
      req   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        req <= '{addr:  MAX_ADDR_W'(req_addr),
                 rmask: MAX_MASK_W'(req_rmask),
                 wmask: MAX_MASK_W'(req_wmask),
                 wdata: MAX_DATA_W'(req_wdata)};
      end
    end
  end

  // Response decode from the state register; data and error are zero outside the strobe
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP) && !reset;
    rsp_err   = rsp_valid && is_err;
    if (rsp_valid && !is_err) begin
      rsp_rdata = read_word & rmask_bits[DATA_W-1:0];
    end else begin
      rsp_rdata = '0;
    end
  end

endmodule
